freq_meter: RTL and testbench
=============================

# freq_meter

Measures the frequency of a slow, asynchronous input signal, such as the divided `clk_hz`/`clk_khz` outputs or an external pin. It counts rising edges over a fixed gate window of `clki` cycles. At the end of each window it latches the count and pulses a valid strobe. It sits on the consumer side of the clock-divider chain, checks divider outputs on the board, and feeds display drivers.

## Interface
- `GATE_CYCLES`, 50000000: gate window length in `clki` cycles (1 s at 50 MHz). Minimum 4.
- `CNT_W`, 27: width of the edge counter and of `freq_out`.
- `clki` input 1: system clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `en` input 1: enables measurement. Level-sensitive.
- `sig_in` input 1: signal under measurement, asynchronous to `clki`.
- `freq_out` output CNT_W: edge count of the last completed window.
- `meas_valid` output 1: one-cycle pulse when `freq_out` updates.
- `ovf` output 1: the last completed window saturated the counter.
- `busy` output 1: the FSM is in COUNT.

## Operation
- `sig_in` passes through a 2-flop synchronizer. A third register provides rising-edge detect, producing `edge_p`, a 1-cycle pulse.
- The FSM has two states:
  - IDLE: `gate_cnt`=0 and `edge_cnt`=0. Goes to COUNT on the cycle `en`=1 is sampled.
  - COUNT: `gate_cnt` increments every cycle. `edge_cnt` increments on `edge_p`.
- When `gate_cnt`==GATE_CYCLES-1 (the terminal cycle):
  - `freq_out` takes `edge_cnt` plus `edge_p` of that cycle, so an edge on the terminal cycle belongs to the closing window.
  - `ovf` is updated.
  - `gate_cnt` and `edge_cnt` clear to 0.
  - The FSM stays in COUNT, so windows are back-to-back and no edge is lost between windows.
- Saturation: `edge_cnt` holds at 2^CNT_W-1. A window that would exceed this reports `freq_out`=all-ones and `ovf`=1.
- `en` deasserted in COUNT: return to IDLE on the next edge and discard the partial window. No `meas_valid` is produced; `freq_out` and `ovf` hold their last values.
- `en` reasserted: a fresh window starts from `gate_cnt`=0.
- The synchronizer flops run regardless of `en`.

## Timing
- Reset values: `freq_out`=0, `meas_valid`=0, `ovf`=0, `busy`=0, FSM in IDLE, synchronizer flops 0.
- Reset asserted mid-window clears everything immediately (asynchronous). No valid is produced.
- `sig_in` rise to `edge_p`: 3 `clki` cycles.
- `en` sampled high at cycle T: `busy`=1 from T+1. The first terminal cycle is T+GATE_CYCLES, and `meas_valid`=1 at T+GATE_CYCLES+1 together with the new `freq_out`.
- Steady state: `meas_valid` pulses exactly every GATE_CYCLES cycles, each pulse one cycle wide.
- There is no back-pressure. The consumer samples `freq_out` on `meas_valid`, and the value is stable until the next pulse.
- Input bandwidth: `sig_in` highs and lows must each last at least 2 `clki` cycles. Faster inputs alias, and this is not flagged.

## Configuration
- `FREQ_METER_PERIOD_EN` defined adds period measurement:
  - Extra ports: `period_out` output CNT_W, and `period_valid` output 1.
  - A free-running `per_cnt` counts `clki` cycles between consecutive `edge_p` pulses, saturating at all-ones.
  - On each `edge_p` after the first since reset or since `en` rose, `period_out` takes `per_cnt`+1 and `per_cnt` restarts.
  - `period_valid` pulses on the following cycle.
  - `per_cnt` runs only while `busy`=1.
  - Reset values of `period_out` and `period_valid` are 0.
- Macro undefined: no period logic and no extra ports. Frequency behaviour is identical either way.

## Structure
- Package `freq_meter_pkg`:
  - FSM state enum (`ST_IDLE`, `ST_COUNT`).
  - Default constants `FM_GATE_CYCLES_DEF`=50000000 and `FM_CNT_W_DEF`=27.
- Sub-module `sync_edge_det`: 2-flop synchronizer plus rising-edge pulse, with `clki`/`rst_n`, input `d_async` and output `rise_p`. It is reusable for buttons and other async inputs.
- The FSM, gate counter, edge counter, output registers and optional period logic are in `freq_meter`.

## Test plan
All scenarios run with GATE_CYCLES=100 and CNT_W=8 unless noted.
- `sig_in` toggling every 5 cycles (period 10), `en`=1 from reset release → first `meas_valid` 101 cycles after `en` sampled; `freq_out`=10 (±1 for phase of the first edge); subsequent windows give 10, and pulses are spaced exactly 100 cycles apart.
- `sig_in` held at 0 → `freq_out`=0, `ovf`=0, `meas_valid` still pulses every 100 cycles.
- CNT_W=3 with period-4 `sig_in` (25 edges per window) → `freq_out`=7, `ovf`=1; then a slower input (period 50, 2 edges) → next window `freq_out`=2, `ovf`=0.
- `en` dropped at `gate_cnt`=60 → no `meas_valid`, `freq_out` unchanged, `busy`=0 next cycle; re-enable → valid after a full 100 cycles.
- Edge arriving exactly on the terminal cycle is counted in the closing window and not the next; `rst_n` pulsed mid-window → all outputs 0 immediately, no spurious valid.
- With `FREQ_METER_PERIOD_EN` and period-10 `sig_in` → `period_valid` pulses every 10 cycles, `period_out`=10; no `period_valid` for the first edge after `en` rises.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types and default constants for the freq_meter block.
package freq_meter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } fm_state_e;

    localparam int unsigned FM_GATE_CYCLES_DEF = 50000000;
    localparam int unsigned FM_CNT_W_DEF       = 27;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous level, plus a one-cycle rising-edge pulse.
module sync_edge_det (
    input  logic clki,
    input  logic rst_n,
    input  logic d_async,
    output logic rise_p
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= d_async;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign rise_p = r_sync2 & ~r_prev;

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter: counts sig_in rising edges per GATE_CYCLES window, back-to-back.
// Optional period measurement between consecutive edges when FREQ_METER_PERIOD_EN is defined.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = FM_GATE_CYCLES_DEF,
    parameter int unsigned CNT_W       = FM_CNT_W_DEF
) (
    input  logic             clki,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_out,
    output logic             meas_valid,
    output logic             ovf,
`ifdef FREQ_METER_PERIOD_EN
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
`endif
    output logic             busy
);

    localparam int unsigned      GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    fm_state_e          r_state;
    logic [GATE_W-1:0]  r_gate_cnt;
    logic [CNT_W-1:0]   r_edge_cnt;
    logic               r_sat;
    logic [CNT_W-1:0]   r_freq;
    logic               r_meas_valid;
    logic               r_ovf;
    logic               r_busy;

    logic               w_edge_p;
    logic               w_terminal;
    logic               w_edge_at_max;
    logic [CNT_W-1:0]   w_edge_next;

    sync_edge_det u_sync (
        .clki    (clki),
        .rst_n   (rst_n),
        .d_async (sig_in),
        .rise_p  (w_edge_p)
    );

    assign w_terminal    = (r_gate_cnt == GATE_LAST);
    assign w_edge_at_max = w_edge_p && (r_edge_cnt == CNT_MAX);
    // Count including this cycle's edge, held at all-ones once full.
    assign w_edge_next   = (w_edge_p && !w_edge_at_max) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_gate_cnt   <= '0;
            r_edge_cnt   <= '0;
            r_sat        <= 1'b0;
            r_freq       <= '0;
            r_meas_valid <= 1'b0;
            r_ovf        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_meas_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_gate_cnt <= '0;
                    r_edge_cnt <= '0;
                    r_sat      <= 1'b0;
                    if (en) begin
                        r_state <= ST_COUNT;
                        r_busy  <= 1'b1;
                    end
                end
                ST_COUNT: begin
                    if (!en) begin
                        // Partial window is discarded; published results hold.
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                        r_gate_cnt <= '0;
                        r_edge_cnt <= '0;
                        r_sat      <= 1'b0;
                    end else if (w_terminal) begin
                        r_freq       <= w_edge_next;
                        r_ovf        <= r_sat | w_edge_at_max;
                        r_meas_valid <= 1'b1;
                        r_gate_cnt   <= '0;
                        r_edge_cnt   <= '0;
                        r_sat        <= 1'b0;
                    end else begin
                        r_gate_cnt <= r_gate_cnt + GATE_W'(1);
                        r_edge_cnt <= w_edge_next;
                        r_sat      <= r_sat | w_edge_at_max;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign freq_out   = r_freq;
    assign meas_valid = r_meas_valid;
    assign ovf        = r_ovf;
    assign busy       = r_busy;

`ifdef FREQ_METER_PERIOD_EN
    logic [CNT_W-1:0] r_per_cnt;
    logic             r_per_armed;
    logic [CNT_W-1:0] r_period;
    logic             r_period_valid;
    logic [CNT_W-1:0] w_per_next;

    assign w_per_next = (r_per_cnt == CNT_MAX) ? CNT_MAX : r_per_cnt + CNT_W'(1);

    // Cycles between consecutive edges; the first edge after enable only arms the counter.
    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            r_per_cnt      <= '0;
            r_per_armed    <= 1'b0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
        end else begin
            r_period_valid <= 1'b0;
            if (r_state != ST_COUNT) begin
                r_per_cnt   <= '0;
                r_per_armed <= 1'b0;
            end else if (w_edge_p) begin
                if (r_per_armed) begin
                    r_period       <= w_per_next;
                    r_period_valid <= 1'b1;
                end
                r_per_cnt   <= '0;
                r_per_armed <= 1'b1;
            end else begin
                r_per_cnt <= w_per_next;
            end
        end
    end

    assign period_out   = r_period;
    assign period_valid = r_period_valid;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: an 8-bit and a 3-bit counter instance share stimulus.
module tb_freq_meter;

    localparam int unsigned GATE = 100;

    typedef struct packed {
        logic [7:0] f;
        logic       o;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       man_lvl;
    logic       gen_lvl;
    logic       sig;
    int         half;
    int         gen_cnt;
    int         k;

    logic [7:0] f8;
    logic       v8, o8, b8;
    logic [2:0] f3;
    logic       v3, o3, b3;
`ifdef FREQ_METER_PERIOD_EN
    logic [7:0] p8;
    logic       pv8;
    logic [2:0] p3;
    logic       pv3;
`endif

    exp_t q8[$];
    exp_t q3[$];
    exp_t e8, e3;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    assign sig = (half == 0) ? man_lvl : gen_lvl;

    freq_meter #(.GATE_CYCLES(GATE), .CNT_W(8)) u_dut8 (
        .clki         (clk),
        .rst_n        (rst_n),
        .en           (en),
        .sig_in       (sig),
        .freq_out     (f8),
        .meas_valid   (v8),
        .ovf          (o8),
`ifdef FREQ_METER_PERIOD_EN
        .period_out   (p8),
        .period_valid (pv8),
`endif
        .busy         (b8)
    );

    freq_meter #(.GATE_CYCLES(GATE), .CNT_W(3)) u_dut3 (
        .clki         (clk),
        .rst_n        (rst_n),
        .en           (en),
        .sig_in       (sig),
        .freq_out     (f3),
        .meas_valid   (v3),
        .ovf          (o3),
`ifdef FREQ_METER_PERIOD_EN
        .period_out   (p3),
        .period_valid (pv3),
`endif
        .busy         (b3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int edges, input int w);
        exp_t r;
        int   mx;
        mx  = (1 << w) - 1;
        r.f = (edges > mx) ? 8'(mx) : 8'(edges);
        r.o = (edges > mx);
        return r;
    endfunction

    task automatic push(input int edges);
        q8.push_back(model(edges, 8));
        q3.push_back(model(edges, 3));
    endtask

    task automatic wait_valid(input int max, output int n);
        n = max + 1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (v8 === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // Square-wave source: toggles every 'half' cycles when half > 0.
    initial begin
        gen_lvl = 1'b0;
        gen_cnt = 0;
        forever begin
            @(negedge clk);
            if (half > 0) begin
                gen_cnt++;
                if (gen_cnt >= half) begin
                    gen_lvl = ~gen_lvl;
                    gen_cnt = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && v8 === 1'b1) begin
            check("q8_has_entry", 32'(q8.size() != 0), 32'd1);
            if (q8.size() != 0) begin
                e8 = q8.pop_front();
                check("freq8", 32'(f8), 32'(e8.f));
                check("ovf8", 32'(o8), 32'(e8.o));
            end
        end
        if (rst_n === 1'b1 && v3 === 1'b1) begin
            check("q3_has_entry", 32'(q3.size() != 0), 32'd1);
            if (q3.size() != 0) begin
                e3 = q3.pop_front();
                check("freq3", 32'(f3), 32'(e3.f));
                check("ovf3", 32'(o3), 32'(e3.o));
            end
        end
    end

`ifdef FREQ_METER_PERIOD_EN
    always @(negedge clk) begin
        if (rst_n === 1'b1 && pv8 === 1'b1 && half > 0)
            check("period8", 32'(p8), 32'((2 * half > 255) ? 255 : 2 * half));
        if (rst_n === 1'b1 && pv3 === 1'b1 && half > 0)
            check("period3", 32'(p3), 32'((2 * half > 7) ? 7 : 2 * half));
    end
`endif

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        half    = 0;
        man_lvl = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_freq8", 32'(f8), 32'd0);
        check("rst_valid8", 32'(v8), 32'd0);
        check("rst_ovf8", 32'(o8), 32'd0);
        check("rst_busy8", 32'(b8), 32'd0);
        check("rst_freq3", 32'(f3), 32'd0);
        check("rst_busy3", 32'(b3), 32'd0);

        // Period-10 input: 10 edges per window; 3-bit instance saturates.
        rst_n = 1'b1;
        half  = 5;
        repeat (40) @(negedge clk);
        en = 1'b1;
        push(10); push(10); push(10);
        @(negedge clk);
        check("busy_on", 32'(b8), 32'd1);
        wait_valid(150, k);
        check("first_latency", 32'(k + 1), 32'd101);
        wait_valid(150, k);
        check("spacing_a1", 32'(k), 32'd100);
        wait_valid(150, k);
        check("spacing_a2", 32'(k), 32'd100);
        en = 1'b0;
        @(negedge clk);
        check("busy_off_a", 32'(b8), 32'd0);

        // Input held low: zero count, valid still pulses.
        half    = 0;
        man_lvl = 1'b0;
        repeat (20) @(negedge clk);
        en = 1'b1;
        push(0); push(0);
        wait_valid(150, k);
        check("latency_low", 32'(k), 32'd101);
        wait_valid(150, k);
        check("spacing_low", 32'(k), 32'd100);
        en = 1'b0;
        repeat (5) @(negedge clk);

        // Period-4 then period-50 input.
        half = 2;
        repeat (30) @(negedge clk);
        en = 1'b1;
        push(25);
        wait_valid(150, k);
        check("latency_p4", 32'(k), 32'd101);
        en   = 1'b0;
        half = 25;
        repeat (120) @(negedge clk);
        en = 1'b1;
        push(2);
        wait_valid(150, k);
        check("latency_p50", 32'(k), 32'd101);

        // Drop enable part-way through a window.
        repeat (60) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("busy_off_drop", 32'(b8), 32'd0);
        check("freq_hold_drop", 32'(f8), 32'd2);
        repeat (150) @(negedge clk);
        check("freq_hold_late", 32'(f8), 32'd2);
        en = 1'b1;
        push(2);
        wait_valid(150, k);
        check("latency_reen", 32'(k), 32'd101);

        // Asynchronous reset mid-window.
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        check("arst_freq8", 32'(f8), 32'd0);
        check("arst_freq3", 32'(f3), 32'd0);
        check("arst_busy8", 32'(b8), 32'd0);
        check("arst_valid8", 32'(v8), 32'd0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);

        // Single edge whose pulse lands on the terminal cycle.
        half    = 0;
        man_lvl = 1'b0;
        repeat (10) @(negedge clk);
        en = 1'b1;
        push(1); push(0);
        k = 151;
        for (int i = 1; i <= 150; i++) begin
            @(negedge clk);
            if (i == 98) man_lvl = 1'b1;
            if (v8 === 1'b1) begin
                k = i;
                break;
            end
        end
        check("latency_term", 32'(k), 32'd101);
        man_lvl = 1'b0;
        wait_valid(150, k);
        check("spacing_term", 32'(k), 32'd100);
        en = 1'b0;
        repeat (10) @(negedge clk);

        check("q8_drained", 32'(q8.size()), 32'd0);
        check("q3_drained", 32'(q3.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
